// File: rtl/zigbee_demod_pkg.sv
// rtl/zigbee_demod_pkg.sv - shared types, constants and sizing helper for the Zigbee phase demodulator
// Contents:
//   phase_t          default-width signed phase word (full circle = 2^16)
//   state_t          demodulator FSM states {IDLE, RUN}
//   CHIPS_PER_SYMBOL chips packed into one correlator word
//   acc_size()       integrator width that holds SPC worst-case deltas
`timescale 1ns/1ps
package zigbee_demod_pkg;

    localparam int CHIPS_PER_SYMBOL = 32;

    typedef logic signed [15:0] phase_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int acc_size(input int w_size, input int spc);
        return w_size + $clog2(spc);
    endfunction

endpackage

// File: rtl/zigbee_phase_chip_demod_if.sv
// rtl/zigbee_phase_chip_demod_if.sv - sample-in / chip-and-word-out bundle for the phase demodulator
// Signals:
//   win, validIn, syncIn               phase sample, its valid, realignment strobe (toward demod)
//   chipOut, chipValid, accOut         sliced chip, its pulse, integrated phase (from demod)
//   wordOut, wordValid                 packed chip word and its pulse (from demod)
// Modports: master = upstream/consumer side, slave = demodulator side.
`timescale 1ns/1ps
interface zigbee_phase_chip_demod_if
    import zigbee_demod_pkg::*;
#(
    parameter int W_SIZE = 16,
    parameter int SPC    = 4,
    parameter int CHIPS  = CHIPS_PER_SYMBOL
);
    localparam int ACC_SIZE = acc_size(W_SIZE, SPC);

    logic signed [W_SIZE-1:0]   win;
    logic                       validIn;
    logic                       syncIn;
    logic                       chipOut;
    logic                       chipValid;
    logic signed [ACC_SIZE-1:0] accOut;
    logic [CHIPS-1:0]           wordOut;
    logic                       wordValid;

    modport master (
        output win, validIn, syncIn,
        input  chipOut, chipValid, accOut, wordOut, wordValid
    );

    modport slave (
        input  win, validIn, syncIn,
        output chipOut, chipValid, accOut, wordOut, wordValid
    );

endinterface

// File: rtl/zigbee_phase_diff.sv
// rtl/zigbee_phase_diff.sv - holds the previous phase and forms the wrapped difference to the current one
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_phase    current phase sample
//   i_load     capture i_phase as the new previous phase
//   o_delta    i_phase - previous phase, modulo 2^W_SIZE (combinational)
`timescale 1ns/1ps
module zigbee_phase_diff #(
    parameter int W_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [W_SIZE-1:0] i_phase,
    input  logic                     i_load,
    output logic signed [W_SIZE-1:0] o_delta
);

    logic signed [W_SIZE-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else if (i_load) begin
            r_prev <= i_phase;
        end
    end

    // Subtracting in W_SIZE bits makes the +pi/-pi seam wrap naturally,
    // so a small forward step across the seam stays a small positive delta.
    assign o_delta = i_phase - r_prev;

endmodule

// File: rtl/zigbee_phase_chip_demod.sv
// rtl/zigbee_phase_chip_demod.sv - differential phase demod: integrate per chip, slice, pack chip words
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        zigbee_phase_chip_demod_if.slave (win/validIn/syncIn in; chip and word results out)
`timescale 1ns/1ps
module zigbee_phase_chip_demod
    import zigbee_demod_pkg::*;
#(
    parameter int W_SIZE = 16,
    parameter int SPC    = 4,
    parameter int CHIPS  = CHIPS_PER_SYMBOL
) (
    input  logic                     clk,
    input  logic                     rst,
    zigbee_phase_chip_demod_if.slave bus
);

    localparam int ACC_SIZE = acc_size(W_SIZE, SPC);
    localparam int SW       = (SPC > 1) ? $clog2(SPC) : 1;
    localparam int CW       = $clog2(CHIPS);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SPC - 1);
    localparam logic [CW-1:0] CHIP_LAST = CW'(CHIPS - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic signed [ACC_SIZE-1:0] r_acc;
    logic [SW-1:0]              r_samp_cnt;
    logic [CW-1:0]              r_chip_cnt;
    logic [CHIPS-1:0]           r_shreg;
    logic                       r_chip_out;
    logic                       r_chip_valid;
    logic signed [ACC_SIZE-1:0] r_acc_out;
    logic [CHIPS-1:0]           r_word_out;
    logic                       r_word_valid;

    logic signed [W_SIZE-1:0]   w_delta;
    logic signed [ACC_SIZE-1:0] w_acc_next;
    logic                       w_chip_bit;
    logic [CHIPS-1:0]           w_word_next;
    logic                       w_accum;
    logic                       w_chip_emit;
    logic                       w_word_emit;

    // prev tracks every valid sample, including the priming sample in IDLE
    // and a sample that arrives together with syncIn.
    zigbee_phase_diff #(
        .W_SIZE (W_SIZE)
    ) u_phase_diff (
        .clk     (clk),
        .rst     (rst),
        .i_phase (bus.win),
        .i_load  (bus.validIn),
        .o_delta (w_delta)
    );

    assign w_acc_next = r_acc + ACC_SIZE'(w_delta);
    assign w_chip_bit = ~w_acc_next[ACC_SIZE-1];   // zero slices to 1

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accum      = 1'b0;
        w_chip_emit  = 1'b0;
        w_word_emit  = 1'b0;
        w_word_next  = r_shreg;
        w_word_next[r_chip_cnt] = w_chip_bit;
        case (r_state)
            IDLE: begin
                if (bus.validIn) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // syncIn outranks emission: a realigning sample only reprimes prev.
                if (bus.validIn && !bus.syncIn) begin
                    w_accum = 1'b1;
                    if (r_samp_cnt == SAMP_LAST) begin
                        w_chip_emit = 1'b1;
                        if (r_chip_cnt == CHIP_LAST) begin
                            w_word_emit = 1'b1;
                        end
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_samp_cnt   <= '0;
            r_chip_cnt   <= '0;
            r_shreg      <= '0;
            r_chip_out   <= 1'b0;
            r_chip_valid <= 1'b0;
            r_acc_out    <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_chip_valid <= w_chip_emit;
            r_word_valid <= w_word_emit;
            if (bus.syncIn) begin
                r_acc      <= '0;
                r_samp_cnt <= '0;
                r_chip_cnt <= '0;
                r_shreg    <= '0;
            end else if (w_accum) begin
                if (w_chip_emit) begin
                    r_acc      <= '0;
                    r_samp_cnt <= '0;
                    r_chip_out <= w_chip_bit;
                    r_acc_out  <= w_acc_next;
                    if (w_word_emit) begin
                        r_word_out <= w_word_next;
                        r_shreg    <= '0;
                        r_chip_cnt <= '0;
                    end else begin
                        r_shreg    <= w_word_next;
                        r_chip_cnt <= r_chip_cnt + CW'(1);
                    end
                end else begin
                    r_acc      <= w_acc_next;
                    r_samp_cnt <= r_samp_cnt + SW'(1);
                end
            end
        end
    end

    assign bus.chipOut   = r_chip_out;
    assign bus.chipValid = r_chip_valid;
    assign bus.accOut    = r_acc_out;
    assign bus.wordOut   = r_word_out;
    assign bus.wordValid = r_word_valid;

endmodule
